// File: rtl/uart_transmit.sv
// UART transmitter: serialises one byte per accepted request into a frame of
// start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits on txd.
module uart_transmit #(
  parameter int unsigned CLKS_PER_BIT = 5,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] word,
  input  logic       send,
  output logic       txd,
  output logic       transmit_ready,
  output logic       transmit_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic            cnt_wrap;

  assign cnt_wrap = (cnt_q == CntLast);

  // txd_d is derived from the next state so the line changes on the same edge
  // as the state, keeping txd purely registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (send) begin
          state_d = StStart;
          shift_d = word;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end

      StStart: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (bit_q == DataLast) begin
            state_d = StStop;
            bit_d   = '0;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        txd_d = 1'b1;
        if (cnt_wrap) begin
          cnt_d = '0;
          if (bit_q == StopLast) begin
            state_d = StIdle;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign txd            = txd_q;
  assign transmit_ready = (state_q == StIdle);
  assign transmit_done  = done_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit at default parameters (5 clk/bit, 8N1).
module tb_uart_transmit;

  logic       clk;
  logic       rst;
  logic [7:0] word;
  logic       send;
  logic       txd;
  logic       transmit_ready;
  logic       transmit_done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  uart_transmit dut (
    .clk           (clk),
    .rst           (rst),
    .word          (word),
    .send          (send),
    .txd           (txd),
    .transmit_ready(transmit_ready),
    .transmit_done (transmit_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (transmit_done === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0] w;
    logic [9:0] frame;   // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop
    int         poke;    // cycle at which a busy-time send is injected, -1 = none
    logic [7:0] poke_w;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered at the negedge of cycle 0 after the accept edge; leaves at the
  // negedge of cycle 50 (the done cycle) after checking it.
  task automatic frame_check(input string name, input logic [9:0] exp, input int poke,
                             input logic [7:0] poke_w);
    for (int k = 0; k < 50; k++) begin
      if (poke >= 0 && k == poke) begin
        send = 1'b1;
        word = poke_w;
      end else if (poke >= 0 && k == poke + 1) begin
        send = 1'b0;
      end
      check($sformatf("%s txd c%0d", name, k), {31'd0, txd}, {31'd0, exp[k/5]});
      check($sformatf("%s ready c%0d", name, k), {31'd0, transmit_ready}, 32'd0);
      check($sformatf("%s done c%0d", name, k), {31'd0, transmit_done}, 32'd0);
      @(negedge clk);
    end
    check($sformatf("%s ready c50", name), {31'd0, transmit_ready}, 32'd1);
    check($sformatf("%s done c50", name), {31'd0, transmit_done}, 32'd1);
    check($sformatf("%s txd c50", name), {31'd0, txd}, 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] w);
    word = w;
    send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
  endtask

  // Line-side receiver: finds the start bit, samples each bit mid-period.
  task automatic rx_capture(input string name, output logic [7:0] rx);
    int wait_cnt = 0;
    rx = '0;
    while (txd !== 1'b0 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    check($sformatf("%s start found", name), {31'd0, (wait_cnt < 200)}, 32'd1);
    repeat (2) @(negedge clk);
    check($sformatf("%s start mid", name), {31'd0, txd}, 32'd0);
    for (int b = 0; b < 8; b++) begin
      repeat (5) @(negedge clk);
      rx[b] = txd;
    end
    repeat (5) @(negedge clk);
    check($sformatf("%s stop mid", name), {31'd0, txd}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lb_words[4];
    logic [7:0] rx;
    int         d0;
    int         wait_cnt;

    vecs[0] = '{w: 8'hA5, frame: 10'h34A, poke: -1, poke_w: 8'h00};
    vecs[1] = '{w: 8'h3C, frame: 10'h278, poke: 20, poke_w: 8'hFF};
    vecs[2] = '{w: 8'h00, frame: 10'h200, poke: -1, poke_w: 8'h00};
    vecs[3] = '{w: 8'hFF, frame: 10'h3FE, poke: -1, poke_w: 8'h00};
    vecs[4] = '{w: 8'h5A, frame: 10'h2B4, poke: -1, poke_w: 8'h00};
    lb_words[0] = 8'h00;
    lb_words[1] = 8'hFF;
    lb_words[2] = 8'hA5;
    lb_words[3] = 8'h5A;

    // Reset held with send asserted: no frame may start.
    rst  = 1'b0;
    send = 1'b1;
    word = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst txd %0d", i), {31'd0, txd}, 32'd1);
      check($sformatf("rst ready %0d", i), {31'd0, transmit_ready}, 32'd1);
      check($sformatf("rst done %0d", i), {31'd0, transmit_done}, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    frame_check("post-rst A5", 10'h34A, -1, 8'h00);
    @(negedge clk);

    // Table of single frames, including the busy-ignore case.
    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].w);
      frame_check($sformatf("vec%0d", v), vecs[v].frame, vecs[v].poke, vecs[v].poke_w);
      @(negedge clk);
      check($sformatf("vec%0d done low", v), {31'd0, transmit_done}, 32'd0);
      check($sformatf("vec%0d idle txd", v), {31'd0, txd}, 32'd1);
    end

    // Back-to-back: send held, next frame starts on the edge ending the done cycle.
    word = 8'h00;
    send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    word = 8'hFF;
    frame_check("b2b first", 10'h200, -1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    frame_check("b2b second", 10'h3FE, -1, 8'h00);
    @(negedge clk);

    // Mid-frame asynchronous reset.
    d0 = done_cnt;
    start_frame(8'h55);
    repeat (17) @(negedge clk);
    check("midrst txd before", {31'd0, txd}, 32'd1);
    check("midrst busy before", {31'd0, transmit_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("midrst txd", {31'd0, txd}, 32'd1);
    check("midrst ready", {31'd0, transmit_ready}, 32'd1);
    check("midrst done", {31'd0, transmit_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("midrst no done", done_cnt - d0, 32'd0);
    start_frame(8'h55);
    frame_check("after midrst 55", 10'h2AA, -1, 8'h00);
    @(negedge clk);

    // Loopback through a line-side receiver with send held high.
    d0   = done_cnt;
    send = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cnt = 0;
      while (transmit_ready !== 1'b1 && wait_cnt < 200) begin
        @(negedge clk);
        wait_cnt++;
      end
      check($sformatf("lb%0d ready seen", i), {31'd0, (wait_cnt < 200)}, 32'd1);
      word = lb_words[i];
      rx_capture($sformatf("lb%0d", i), rx);
      if (i == 3) send = 1'b0;
      check($sformatf("lb%0d word", i), {24'd0, rx}, {24'd0, lb_words[i]});
    end
    repeat (6) @(negedge clk);
    check("lb done count", done_cnt - d0, 32'd4);
    check("lb final ready", {31'd0, transmit_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
